// File: rtl/ram_port.sv
`default_nettype none
// ============================================================================
// Module   : ram_port
// Brief    : Byte-organised RAM behind the memory controller; word requests are
//            split into two little-endian byte cycles on an 8-bit array.
// Option   : RAM_PORT_WRITE_PROTECT_EN rejects writes that start below PROTECT_TOP.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port #(
  parameter int          DEPTH       = 65536,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] PROTECT_TOP = 16'h0064
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_exec,
  input  logic        I_write,
  input  logic [1:0]  I_size,
  input  logic [15:0] I_addr,
  input  logic [15:0] I_data,
  output logic        O_ready,
  output logic [15:0] O_data,
  output logic        O_data_ready,
  output logic        O_fault
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef RAM_PORT_WRITE_PROTECT_EN
  localparam bit c_PROT_EN = 1'b1;
`else
  localparam bit c_PROT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_BYTE0 = 3'd2,
    S_BYTE1 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_wait_cnt;
  logic [c_AW-1:0]   r_addr;
  logic              r_write;
  logic              r_word;
  logic              r_illegal;
  logic              r_prot;
  logic [15:0]       r_wdata;
  logic [15:0]       r_data;
  logic [7:0]        r_mem [DEPTH];

  logic              w_accept;
  logic              w_legal;
  logic              w_prot;
  logic              w_we;
  logic [c_AW-1:0]   w_mem_addr;
  logic [7:0]        w_wbyte;

  assign w_accept   = (r_state == S_IDLE) && I_exec;
  assign w_legal    = (I_size == 2'd1) || (I_size == 2'd2);
  // Only the first byte address is tested, so a word straddling the boundary is rejected whole.
  assign w_prot     = c_PROT_EN && I_write && (I_addr < PROTECT_TOP);
  assign w_mem_addr = (r_state == S_BYTE1) ? r_addr + c_AW'(1) : r_addr;
  assign w_wbyte    = (r_state == S_BYTE1) ? r_wdata[15:8] : r_wdata[7:0];
  assign w_we       = r_write && !r_prot && ((r_state == S_BYTE0) || (r_state == S_BYTE1));

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    O_ready      = 1'b0;
    O_data_ready = 1'b0;
    O_fault      = 1'b0;
    case (r_state)
      S_IDLE: begin
        O_ready = 1'b1;
        if (I_exec) begin
          if (!w_legal)             w_next = S_DONE;
          else if (WAIT_STATES > 0) w_next = S_WAIT;
          else                      w_next = S_BYTE0;
        end
      end
      S_WAIT:  if (r_wait_cnt <= 4'd1) w_next = S_BYTE0;
      S_BYTE0: w_next = r_word ? S_BYTE1 : S_DONE;
      S_BYTE1: w_next = S_DONE;
      S_DONE: begin
        O_data_ready = !r_write;
        O_fault      = r_illegal || r_prot;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_wait_cnt <= 4'd0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_word     <= 1'b0;
      r_illegal  <= 1'b0;
      r_prot     <= 1'b0;
      r_wdata    <= 16'h0000;
      r_data     <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_addr     <= I_addr[c_AW-1:0];
        r_write    <= I_write;
        r_word     <= (I_size == 2'd2);
        r_illegal  <= !w_legal;
        r_prot     <= w_prot;
        r_wdata    <= I_data;
        r_wait_cnt <= 4'(WAIT_STATES);
        if (!w_legal && !I_write) r_data <= 16'h0000;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if ((r_state == S_BYTE0) && !r_write) begin
        r_data[7:0] <= r_mem[w_mem_addr];
        if (!r_word) r_data[15:8] <= 8'h00;
      end
      if ((r_state == S_BYTE1) && !r_write) begin
        r_data[15:8] <= r_mem[w_mem_addr];
      end
    end
  end

  // Array has no reset so contents survive a reset pulse.
  always_ff @(posedge I_clk) begin
    if (w_we) r_mem[w_mem_addr] <= w_wbyte;
  end

  assign O_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_ram_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port
// Brief    : Directed self-checking bench for ram_port (W=0 and W=3 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exec0, exec1, wr;
  logic [1:0]  sz;
  logic [15:0] addr, wdata;
  logic        rdy0, rdy1, dr0, dr1, f0, f1;
  logic [15:0] dat0, dat1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ram_port #(.DEPTH(65536), .WAIT_STATES(0), .PROTECT_TOP(16'h0064)) u_dut0 (
    .I_clk(clk), .I_reset_n(rst_n), .I_exec(exec0), .I_write(wr), .I_size(sz),
    .I_addr(addr), .I_data(wdata), .O_ready(rdy0), .O_data(dat0),
    .O_data_ready(dr0), .O_fault(f0)
  );

  ram_port #(.DEPTH(65536), .WAIT_STATES(3), .PROTECT_TOP(16'h0064)) u_dut1 (
    .I_clk(clk), .I_reset_n(rst_n), .I_exec(exec1), .I_write(wr), .I_size(sz),
    .I_addr(addr), .I_data(wdata), .O_ready(rdy1), .O_data(dat1),
    .O_data_ready(dr1), .O_fault(f1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one request; report cycle (relative to accept edge) of data_ready, fault and ready.
  task automatic req(input int sel, input logic w, input logic [1:0] s,
                     input logic [15:0] a, input logic [15:0] d, input bit poke,
                     output logic [15:0] rd, output int dr_c, output int f_c, output int rdy_c);
    @(negedge clk);
    wr = w; sz = s; addr = a; wdata = d;
    if (sel == 0) exec0 = 1'b1; else exec1 = 1'b1;
    @(posedge clk);
    #1;
    exec0 = 1'b0; exec1 = 1'b0;
    dr_c = 0; f_c = 0; rdy_c = 0; rd = 16'h0000;
    for (int c = 1; c <= 40 && rdy_c == 0; c++) begin
      @(negedge clk);
      if (((sel == 0) ? dr0 : dr1) && dr_c == 0) begin
        dr_c = c;
        rd   = (sel == 0) ? dat0 : dat1;
      end
      if (((sel == 0) ? f0 : f1) && f_c == 0) f_c = c;
      if ((sel == 0) ? rdy0 : rdy1) rdy_c = c;
      if (poke && c == 1) begin
        if (sel == 0) exec0 = 1'b1; else exec1 = 1'b1;
        wr = 1'b1; sz = 2'd1; addr = 16'h0400; wdata = 16'h0055;
      end
      if (poke && c == 2) begin
        exec0 = 1'b0; exec1 = 1'b0;
      end
    end
    if (rdy_c == 0) check("timeout", 32'd0, 32'd1);
  endtask

  logic [15:0] rd;
  int dr_c, f_c, rdy_c;

  initial begin
    rst_n = 1'b0; exec0 = 1'b0; exec1 = 1'b0; wr = 1'b0; sz = 2'd0;
    addr = 16'h0000; wdata = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, rdy0}, 32'd1);
    check("rst_data", {16'd0, dat0}, 32'h0);
    check("rst_dr_flt", {30'd0, dr0, f0}, 32'd0);
    check("rst_ready_w3", {31'd0, rdy1}, 32'd1);
    rst_n = 1'b1;

    // W=0 word write then word read, byte read of upper byte
    req(0, 1'b1, 2'd2, 16'h0100, 16'hBEEF, 1'b0, rd, dr_c, f_c, rdy_c);
    check("wwr_ready_cyc", rdy_c, 4);
    check("wwr_no_pulse", dr_c + f_c, 0);
    req(0, 1'b0, 2'd2, 16'h0100, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    check("wrd_data", {16'd0, rd}, 32'hBEEF);
    check("wrd_dr_cyc", dr_c, 3);
    check("wrd_ready_cyc", rdy_c, 4);
    req(0, 1'b0, 2'd1, 16'h0101, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    check("brd_data", {16'd0, rd}, 32'h00BE);
    check("brd_dr_cyc", dr_c, 2);
    check("brd_ready_cyc", rdy_c, 3);

    // W=3 byte write then byte read
    req(1, 1'b1, 2'd1, 16'h0200, 16'h005A, 1'b0, rd, dr_c, f_c, rdy_c);
    check("w3_wr_ready_cyc", rdy_c, 6);
    req(1, 1'b0, 2'd1, 16'h0200, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    check("w3_rd_data", {16'd0, rd}, 32'h005A);
    check("w3_rd_dr_cyc", dr_c, 5);
    check("w3_rd_ready_cyc", rdy_c, 6);

    // Wrap at top of array
    req(0, 1'b1, 2'd2, 16'hFFFF, 16'h1234, 1'b0, rd, dr_c, f_c, rdy_c);
    req(0, 1'b0, 2'd1, 16'hFFFF, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    check("wrap_top", {16'd0, rd}, 32'h0034);
    req(0, 1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    check("wrap_zero", {16'd0, rd}, 32'h0012);
    req(0, 1'b0, 2'd2, 16'hFFFF, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    check("wrap_word", {16'd0, rd}, 32'h1234);

    // Illegal sizes
    req(0, 1'b1, 2'd1, 16'h0010, 16'h0077, 1'b0, rd, dr_c, f_c, rdy_c);
    req(0, 1'b0, 2'd0, 16'h0010, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    check("ill_rd_data", {16'd0, rd}, 32'h0000);
    check("ill_rd_dr_cyc", dr_c, 1);
    check("ill_rd_flt_cyc", f_c, 1);
    check("ill_rd_ready_cyc", rdy_c, 2);
    req(0, 1'b1, 2'd3, 16'h0010, 16'h0099, 1'b0, rd, dr_c, f_c, rdy_c);
    check("ill_wr_flt_cyc", f_c, 1);
    check("ill_wr_no_dr", dr_c, 0);
    req(0, 1'b0, 2'd1, 16'h0010, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    check("ill_unchanged", {16'd0, rd}, 32'h0077);

    // Exec pulse during a busy word read is dropped
    req(0, 1'b1, 2'd2, 16'h0300, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    req(0, 1'b1, 2'd1, 16'h0400, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    req(0, 1'b0, 2'd2, 16'h0100, 16'h0000, 1'b1, rd, dr_c, f_c, rdy_c);
    check("poke_rd_data", {16'd0, rd}, 32'hBEEF);
    check("poke_rd_dr_cyc", dr_c, 3);
    req(0, 1'b0, 2'd1, 16'h0400, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    check("poke_dropped", {16'd0, rd}, 32'h0000);

    // Reset during BYTE1 of a word write
    @(negedge clk);
    wr = 1'b1; sz = 2'd2; addr = 16'h0300; wdata = 16'hAAAA; exec0 = 1'b1;
    @(posedge clk);
    #1 exec0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, rdy0}, 32'd1);
    check("abort_no_pulse", {30'd0, dr0, f0}, 32'd0);
    @(negedge clk);
    check("abort_data_rst", {16'd0, dat0}, 32'h0000);
    check("abort_no_pulse2", {30'd0, dr0, f0}, 32'd0);
    rst_n = 1'b1;
    req(0, 1'b0, 2'd1, 16'h0300, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    check("abort_byte0", {16'd0, rd}, 32'h00AA);
    req(0, 1'b0, 2'd1, 16'h0301, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    check("abort_byte1", {16'd0, rd}, 32'h0000);

    // Write-protect boundary
    req(0, 1'b1, 2'd1, 16'h0064, 16'h0011, 1'b0, rd, dr_c, f_c, rdy_c);
    check("prot_64_pre_flt", f_c, 0);
    req(0, 1'b1, 2'd2, 16'h0063, 16'hCCDD, 1'b0, rd, dr_c, f_c, rdy_c);
`ifdef RAM_PORT_WRITE_PROTECT_EN
    check("prot_word_flt_cyc", f_c, 3);
    check("prot_word_ready_cyc", rdy_c, 4);
    req(0, 1'b0, 2'd1, 16'h0064, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    check("prot_64_kept", {16'd0, rd}, 32'h0011);
    req(0, 1'b0, 2'd1, 16'h0063, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    check("prot_63_not_written", {31'd0, rd == 16'h00DD}, 32'd0);
    req(0, 1'b1, 2'd1, 16'h0064, 16'h0042, 1'b0, rd, dr_c, f_c, rdy_c);
    check("prot_64_wr_flt", f_c, 0);
    req(0, 1'b0, 2'd1, 16'h0064, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    check("prot_64_written", {16'd0, rd}, 32'h0042);
`else
    check("noprot_word_flt", f_c, 0);
    check("noprot_word_ready_cyc", rdy_c, 4);
    req(0, 1'b0, 2'd2, 16'h0063, 16'h0000, 1'b0, rd, dr_c, f_c, rdy_c);
    check("noprot_word_data", {16'd0, rd}, 32'hCCDD);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
